// File: rtl/i2s_tx_pkg.sv
// Shared defaults and types for the audio I/O blocks (I2S transmitter and friends).
// Frame layout: one left slot followed by one right slot, samples MSB-aligned in each slot.
package i2s_tx_pkg;

  localparam int unsigned I2S_DATA_W   = 24;
  localparam int unsigned I2S_SLOT_W   = 32;
  localparam int unsigned I2S_BCLK_DIV = 4;
  localparam int unsigned FRAME_BITS   = 2 * I2S_SLOT_W;

  // Holding-buffer state; encodings are relied on by other audio blocks.
  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } buf_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// I2S timing generator: BCLK divider, bit-period counter, LRCLK, and the
// fall-event / frame-load strobes that pace the serialiser.
module i2s_clk_gen
  import i2s_tx_pkg::*;
#(
  parameter int unsigned SLOT_W   = I2S_SLOT_W,
  parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic bclk,
  output logic lrclk,
  output logic fe,
  output logic frame_load
);

  localparam int unsigned NBits = 2 * SLOT_W;
  localparam int unsigned DivW  = cnt_width(BCLK_DIV);
  localparam int unsigned BitW  = cnt_width(NBits);

  localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);
  localparam logic [DivW-1:0] DivRise = DivW'(BCLK_DIV / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(NBits - 1);
  localparam logic [BitW-1:0] BitSlot = BitW'(SLOT_W);

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic            bclk_q, bclk_d;
  logic            lrclk_q, lrclk_d;

  // Strobes describe the upcoming edge, so they decode the current counter state.
  assign fe         = (div_cnt_q == DivLast);
  assign frame_load = fe && (bit_cnt_q == '0);

  always_comb begin
    div_cnt_d = fe ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    bclk_d    = bclk_q;
    lrclk_d   = lrclk_q;
    if (div_cnt_q == DivRise) begin
      bclk_d = 1'b1;
    end
    if (fe) begin
      bclk_d    = 1'b0;
      bit_cnt_d = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + 1'b1;
      lrclk_d   = (bit_cnt_d >= BitSlot);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
    end
  end

  assign bclk  = bclk_q;
  assign lrclk = lrclk_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep stereo holding buffer feeding a frame shift register,
// shifted MSB-first with the standard one-BCLK delay after each LRCLK transition.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_W   = I2S_DATA_W,
  parameter int unsigned SLOT_W   = I2S_SLOT_W,
  parameter int unsigned BCLK_DIV = I2S_BCLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun
);

  localparam int unsigned NBits = 2 * SLOT_W;

  buf_state_e        state_q, state_d;
  logic [DATA_W-1:0] left_q, left_d;
  logic [DATA_W-1:0] right_q, right_d;
  logic [NBits-1:0]  shreg_q, shreg_d;
  logic [NBits-1:0]  frame_word;
  logic              underrun_q, underrun_d;
  logic              fe;
  logic              frame_load;
  logic              accept;

  i2s_clk_gen #(
    .SLOT_W   (SLOT_W),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .bclk       (bclk),
    .lrclk      (lrclk),
    .fe         (fe),
    .frame_load (frame_load)
  );

  assign sample_ready = (state_q == StEmpty);
  assign accept       = sample_valid && sample_ready;

  // An empty buffer yields a silent frame; padding bits below each sample stay zero.
  always_comb begin
    frame_word = '0;
    if (state_q == StFull) begin
      frame_word[NBits-1 -: DATA_W]  = left_q;
      frame_word[SLOT_W-1 -: DATA_W] = right_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    left_d     = left_q;
    right_d    = right_q;
    underrun_d = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          left_d  = left_in;
          right_d = right_in;
          state_d = StFull;
        end
        // A capture on this same edge is kept for the next frame, not bypassed.
        underrun_d = frame_load;
      end
      StFull: begin
        if (frame_load) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    shreg_d = shreg_q;
    if (frame_load) begin
      shreg_d = frame_word;
    end else if (fe) begin
      shreg_d = {shreg_q[NBits-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      left_q     <= '0;
      right_q    <= '0;
      shreg_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      left_q     <= left_d;
      right_q    <= right_d;
      shreg_q    <= shreg_d;
      underrun_q <= underrun_d;
    end
  end

  // The shift register MSB is the registered serial output.
  assign sdata    = shreg_q[NBits-1];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a negedge monitor rebuilds each 64-bit frame from sdata on
// BCLK rising edges and tallies underrun pulses per frame; the main process compares.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] left_in = '0;
  logic [23:0] right_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        underrun;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [63:0] frames [0:7];
  int          ur_cnt [0:7];
  int          rise_cnt;
  logic        prev_bclk;

  i2s_tx #(
    .DATA_W   (24),
    .SLOT_W   (32),
    .BCLK_DIV (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .left_in      (left_in),
    .right_in     (right_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Rise r (r >= 1) lies in bit period r mod 64 and carries frame bit 64 - ((r-1) mod 64 + 1).
  always @(negedge clk) begin
    int r;
    int f;
    if (!rst_n) begin
      rise_cnt  = 0;
      prev_bclk = 1'b0;
      for (int i = 0; i < 8; i++) begin
        frames[i] = '0;
        ur_cnt[i] = 0;
      end
    end else begin
      if (bclk && !prev_bclk) begin
        if (rise_cnt >= 1) begin
          r = rise_cnt - 1;
          f = r / 64 + 1;
          if (f < 8) frames[f][63 - (r % 64)] = sdata;
        end
        rise_cnt++;
      end
      prev_bclk = bclk;
      if (underrun) begin
        f = (rise_cnt > 0) ? (rise_cnt - 1) / 64 + 1 : 0;
        if (f < 8) ur_cnt[f]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    left_in      = '0;
    right_in     = '0;
    repeat (n) tick();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Holds valid until the handshake edge; acc is the edge index (cyc) of the capture.
  task automatic send(input logic [23:0] l, input logic [23:0] r, output int acc);
    int n = 0;
    left_in      = l;
    right_in     = r;
    sample_valid = 1'b1;
    while (!sample_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check_eq("send_ready_timeout", sample_ready, 1);
    tick();
    acc          = cyc;
    sample_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int e_bclk, e_lr, e_sd, e_ur;
    logic exp_b, exp_l;

    // 1: reset values and idle timing
    rst_n = 1'b0;
    repeat (3) tick();
    check_eq("rst_bclk", bclk, 0);
    check_eq("rst_lrclk", lrclk, 0);
    check_eq("rst_sdata", sdata, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_ready", sample_ready, 1);
    rst_n = 1'b1;
    cyc   = 0;
    e_bclk = 0; e_lr = 0; e_sd = 0; e_ur = 0;
    for (int k = 1; k <= 520; k++) begin
      tick();
      exp_b = ((k % 4) == 2) || ((k % 4) == 3);
      exp_l = (((k / 4) % 64) >= 32);
      if (bclk !== exp_b) e_bclk++;
      if (lrclk !== exp_l) e_lr++;
      if (sdata !== 1'b0) e_sd++;
      if (underrun !== ((k % 256) == 4)) e_ur++;
    end
    check_eq("idle_bclk_pattern_errs", e_bclk, 0);
    check_eq("idle_lrclk_pattern_errs", e_lr, 0);
    check_eq("idle_sdata_errs", e_sd, 0);
    check_eq("idle_underrun_errs", e_ur, 0);
    check_eq("idle_ur_frame1", ur_cnt[1], 1);
    check_eq("idle_ur_frame2", ur_cnt[2], 1);

    // 2: single frame
    do_reset(2);
    send(24'hA5A5A5, 24'h123456, acc);
    check_eq("t2_accept_cycle", acc, 1);
    check_eq("t2_ready_drop", sample_ready, 0);
    run_to(520);
    check_eq("t2_frame1", frames[1], 64'hA5A5A500_12345600);
    check_eq("t2_ur_frame1", ur_cnt[1], 0);
    check_eq("t2_frame2_zero", frames[2], 64'h0);
    check_eq("t2_ur_frame2", ur_cnt[2], 1);

    // 3: back-pressure with valid held continuously
    do_reset(2);
    send(24'h000001, 24'h000002, acc);
    check_eq("t3_accept1", acc, 1);
    send(24'h000003, 24'h000004, acc);
    check_eq("t3_accept2", acc, 5);
    send(24'h000005, 24'h000006, acc);
    check_eq("t3_accept3", acc, 261);
    run_to(780);
    check_eq("t3_frame1", frames[1], 64'h00000100_00000200);
    check_eq("t3_frame2", frames[2], 64'h00000300_00000400);
    check_eq("t3_frame3", frames[3], 64'h00000500_00000600);
    check_eq("t3_ur_total", ur_cnt[1] + ur_cnt[2] + ur_cnt[3], 0);

    // 4: underrun then recovery
    do_reset(2);
    run_to(10);
    send(24'h7FFFFF, 24'h800000, acc);
    check_eq("t4_accept", acc, 11);
    run_to(520);
    check_eq("t4_frame1_zero", frames[1], 64'h0);
    check_eq("t4_ur_frame1", ur_cnt[1], 1);
    check_eq("t4_frame2", frames[2], 64'h7FFFFF00_80000000);
    check_eq("t4_ur_frame2", ur_cnt[2], 0);

    // 5: handshake on the same edge as an empty frame load
    do_reset(2);
    run_to(3);
    send(24'h5A5A5A, 24'hC3C3C3, acc);
    check_eq("t5_accept_on_load", acc, 4);
    check_eq("t5_ready_after", sample_ready, 0);
    run_to(520);
    check_eq("t5_frame1_zero", frames[1], 64'h0);
    check_eq("t5_ur_frame1", ur_cnt[1], 1);
    check_eq("t5_frame2", frames[2], 64'h5A5A5A00_C3C3C300);
    check_eq("t5_ur_frame2", ur_cnt[2], 0);

    // 6: reset mid-frame (bit period 40) while the buffer is full
    do_reset(2);
    send(24'h111111, 24'h333333, acc);
    send(24'h444444, 24'h555555, acc);
    check_eq("t6_accept2", acc, 5);
    run_to(161);
    check_eq("t6_pre_ready", sample_ready, 0);
    check_eq("t6_pre_lrclk", lrclk, 1);
    check_eq("t6_pre_sdata", sdata, 1);
    rst_n = 1'b0;
    tick();
    check_eq("t6_rst_bclk", bclk, 0);
    check_eq("t6_rst_lrclk", lrclk, 0);
    check_eq("t6_rst_sdata", sdata, 0);
    check_eq("t6_rst_ready", sample_ready, 1);
    check_eq("t6_rst_underrun", underrun, 0);
    rst_n = 1'b1;
    cyc   = 0;
    run_to(520);
    check_eq("t6_frame1_zero", frames[1], 64'h0);
    check_eq("t6_ur_frame1", ur_cnt[1], 1);
    check_eq("t6_frame2_zero", frames[2], 64'h0);
    check_eq("t6_ur_frame2", ur_cnt[2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_tx.md
Name: i2s_tx

Overview:
Serialises filtered stereo samples from the equaliser datapath onto a standard I2S bus that drives the output DAC. It is the output-side counterpart to the sample consumers upstream. Parallel 24-bit left/right words arrive over a valid/ready handshake into a one-deep holding buffer. The block generates BCLK and LRCLK from the system clock and shifts the data out MSB-first with the I2S one-bit delay.

Parameters:
DATA_W, 24, audio sample width in bits (DATA_W ≤ SLOT_W).
SLOT_W, 32, BCLK periods per channel slot; unused LSB positions are padded with 0.
BCLK_DIV, 4, clk cycles per BCLK period (even, ≥2).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
left_in  in  DATA_W  signed left sample
right_in  in  DATA_W  signed right sample
sample_valid  in  1  left_in/right_in are valid
sample_ready  out  1  holding buffer can accept a sample
bclk  out  1  I2S bit clock
lrclk  out  1  I2S word select (0 = left, 1 = right)
sdata  out  1  I2S serial data
underrun  out  1  one-cycle pulse when a frame starts with the holding buffer empty

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-low: state is cleared on the clk edge when rst_n is 0. All outputs are registered except sample_ready.
- Reset values: bclk=0, lrclk=0, sdata=0, underrun=0, div_cnt=0, bit_cnt=0, holding buffer EMPTY, shift register all 0. sample_ready=1 during and after reset.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk is set to 1 on the edge where div_cnt goes BCLK_DIV/2-1 → BCLK_DIV/2.
  - bclk is cleared on the edge where div_cnt wraps BCLK_DIV-1 → 0. This edge is the "fall event" (fe).
- Bit counter: bit_cnt runs 0..2*SLOT_W-1, increments on each fe, and wraps. It is the current bit period index.
- Word select: lrclk is updated on fe to (new bit_cnt ≥ SLOT_W).
- Data: sdata is updated only on fe, so it is stable while bclk is high.
- Frame load: on the fe that moves bit_cnt 0 → 1, load the 2*SLOT_W shift register as {left, zero pad, right, zero pad}, and set sdata to the left MSB.
- Shifting: on every other fe, shift left by one and output the new MSB.
  - Left MSB therefore appears one BCLK after lrclk falls.
  - Right MSB appears one BCLK after lrclk rises.
  - In bit period 0, sdata carries the final bit of the previous frame.
- Frame period: 2*SLOT_W*BCLK_DIV clk cycles (256 with defaults).
- Holding-buffer FSM (states EMPTY and FULL):
  - sample_ready = (state == EMPTY).
  - EMPTY → FULL when sample_valid && sample_ready; the sample pair is captured.
  - FULL → EMPTY on the frame-load edge.
- Underrun: if the frame-load edge finds the buffer EMPTY, load zeros and assert underrun for exactly one cycle on that edge.
  - A handshake in the same cycle as an EMPTY frame load still underruns. The captured sample is used at the next frame; there is no bypass.
- Back-pressure: while FULL, sample_valid is ignored. The upstream must hold its data until sample_ready returns to 1, which is the cycle after a frame load.
- Reset mid-frame: outputs return to reset values on the next edge. Any partially sent frame and any held sample are discarded, and the next frame starts cleanly from bit_cnt=0.
- No arithmetic beyond the counters. Samples pass bit-exact and are not rounded.

Decomposition:
- Shared header/package: defaults for DATA_W, SLOT_W and BCLK_DIV; the frame-layout constant FRAME_BITS = 2*SLOT_W; holding FSM state encodings EMPTY=1'b0 and FULL=1'b1. The equaliser top and other audio I/O blocks use the same header.
- One sub-module, i2s_clk_gen: the div_cnt/bit_cnt counters, registered bclk/lrclk, and the fe and frame-load strobes. The top level holds the buffer FSM, shift register and underrun logic.

Test Plan:
1. Reset then idle with defaults: bclk has period 4 (2 cycles low, 2 high), lrclk has period 256, sdata stays 0, and underrun pulses once per frame on each frame-load edge.
2. Single frame, left=0xA5A5A5, right=0x123456, valid in the first cycle after reset:
   - sample_ready drops the next cycle.
   - Bit periods 1..24 carry 0xA5A5A5 MSB-first, 25..32 are 0; bit periods 33..56 carry 0x123456, 57..64 are 0.
   - Sampled on bclk rising edges; no underrun.
3. Back-pressure: valid held continuously with three pairs, L/R = 0x000001/0x000002, 0x000003/0x000004, 0x000005/0x000006:
   - Pair 2 is accepted only in the cycle after pair 1's frame load.
   - Pair 3 is held until frame 2 loads.
   - Frames 1–3 carry pairs 1–3 in order with no duplication or loss.
4. Underrun then recovery: no sample for frame 1, then 0x7FFFFF/0x800000 presented:
   - Frame 1 is all zeros with an underrun pulse.
   - Frame 2 carries 0x7FFFFF/0x800000 exactly; no pulse.
5. Handshake coincident with an EMPTY frame-load edge: underrun asserts and that frame is zeros; the sample is emitted in the following frame.
6. rst_n low for 1 cycle at bit_cnt=40 while FULL: the next cycle shows bclk=0, lrclk=0, sdata=0, sample_ready=1; the held sample is dropped and the first frame after reset underruns.
